// File: rtl/pkg_en.sv
// pkg_en: shared ElectronNest token types, bus widths and external-memory bridge FSM states.
package pkg_en;
  localparam int WIDTH_DATA = 16;
  localparam int WIDTH_EXADDR = 8;
  typedef struct packed {
    logic v;
    logic a;
    logic r;
    logic c;
    logic [WIDTH_EXADDR-1:0] i;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;
  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;
  typedef enum logic [1:0] {IDLE, BOOT, SERVE, HOLD} ext_mem_state_t;
endpackage

// File: rtl/ext_mem_ld_queue.sv
// ext_mem_ld_queue: in-order load return path with a one-entry pending request and a one-entry skid.
// EXTEND_MEM_EN adds an address tag travelling alongside each returned word.
module ext_mem_ld_queue
  import pkg_en::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    active,
  input  logic                    port_free,
  input  logic                    ld_req,
  input  logic [WIDTH_EXADDR-1:0] ld_addr,
  input  logic                    bt_n,
  input  logic [WIDTH_DATA-1:0]   rdata,
  output logic                    rd_en,
  output logic [WIDTH_EXADDR-1:0] rd_addr,
  output logic                    stall,
  output logic                    pend_v,
  output FTk_t                    tok
);
  logic pend_v_q, pend_v_d, rv_q, skid_v_q, skid_v_d, out_v_q, out_v_d;
  logic [WIDTH_EXADDR-1:0] pend_a_q, pend_a_d, out_i;
  logic [WIDTH_DATA-1:0] skid_d_q, skid_d_d, out_d_q, out_d_d;
  assign stall = out_v_q & bt_n;
  // a read may only be issued if its data is guaranteed a place to land next cycle
  assign rd_en = port_free & ~stall & (~skid_v_q | ~rv_q) & (pend_v_q | ld_req);
  assign rd_addr = pend_v_q ? pend_a_q : ld_addr;
  assign pend_v = pend_v_q;
  always_comb begin
    pend_v_d = pend_v_q & ~rd_en;
    pend_a_d = pend_a_q;
    if (active & ld_req & (pend_v_q | ~rd_en)) begin
      pend_v_d = 1'b1;
      pend_a_d = ld_addr;
    end
    out_v_d = stall ? out_v_q : (skid_v_q | rv_q);
    out_d_d = stall ? out_d_q : (skid_v_q ? skid_d_q : rdata);
    skid_v_d = stall ? (skid_v_q | rv_q) : (skid_v_q & rv_q);
    skid_d_d = (stall & ~rv_q) ? skid_d_q : rdata;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_v_q <= 1'b0;
      pend_a_q <= '0;
      rv_q <= 1'b0;
      skid_v_q <= 1'b0;
      skid_d_q <= '0;
      out_v_q <= 1'b0;
      out_d_q <= '0;
    end else begin
      pend_v_q <= pend_v_d;
      pend_a_q <= pend_a_d;
      rv_q <= rd_en;
      skid_v_q <= skid_v_d;
      skid_d_q <= skid_d_d;
      out_v_q <= out_v_d;
      out_d_q <= out_d_d;
    end
  end
`ifdef EXTEND_MEM_EN
  logic [WIDTH_EXADDR-1:0] ra_q, skid_i_q, skid_i_d, out_i_q, out_i_d;
  always_comb begin
    out_i_d = stall ? out_i_q : (skid_v_q ? skid_i_q : ra_q);
    skid_i_d = (stall & ~rv_q) ? skid_i_q : ra_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ra_q <= '0;
      skid_i_q <= '0;
      out_i_q <= '0;
    end else begin
      ra_q <= rd_addr;
      skid_i_q <= skid_i_d;
      out_i_q <= out_i_d;
    end
  end
  assign out_i = out_i_q;
`else
  assign out_i = '0;
`endif
  assign tok = '{v: out_v_q, a: 1'b0, r: 1'b0, c: 1'b0, i: out_i, d: out_d_q};
endmodule

// File: rtl/ext_mem_bridge.sv
// ext_mem_bridge: boots ElectronNest from BRAM, then serves in-order loads and stores on one BRAM port.
// EXTEND_MEM_EN tags every returned token with its source address in O_Ld_FTk.i.
module ext_mem_bridge
  import pkg_en::*;
#(
  parameter int DEPTH_BOOT = 5,
  parameter int NUM_BOOT_PAD = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Boot,
  input  logic                    I_Ld_Req,
  input  logic [WIDTH_EXADDR-1:0] I_Ld_Addr,
  output FTk_t                    O_Ld_FTk,
  input  BTk_t                    I_Ld_BTk,
  input  logic                    I_St_Req,
  input  logic [WIDTH_EXADDR-1:0] I_St_Addr,
  input  FTk_t                    I_St_FTk,
  output BTk_t                    O_St_BTk,
  output logic                    O_Mem_En,
  output logic                    O_Mem_We,
  output logic [WIDTH_EXADDR-1:0] O_Mem_Addr,
  output logic [WIDTH_DATA-1:0]   O_Mem_WData,
  input  logic [WIDTH_DATA-1:0]   I_Mem_RData,
  output logic                    O_Busy
);
  localparam int TOT = NUM_BOOT_PAD + DEPTH_BOOT;
  localparam int CW = $clog2(TOT + 1);
  ext_mem_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, nxt;
  logic st_n, st_ok, active, stall, pend_v, rd_en, boot_rd, in_pad, unused_ok;
  logic [WIDTH_EXADDR-1:0] rd_addr, boot_addr, boot_i;
  FTk_t q_tok;
  assign st_n = (state_q == IDLE) | (state_q == BOOT);
  assign active = ~st_n;
  assign st_ok = I_St_Req & I_St_FTk.v & ~st_n;
  // boot words are fetched one cycle ahead so the BRAM output feeds the token directly
  assign nxt = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
  assign boot_rd = ~reset & (((state_q == IDLE) & I_Boot) | (state_q == BOOT))
                 & (nxt >= CW'(NUM_BOOT_PAD)) & (nxt < CW'(TOT));
  assign boot_addr = WIDTH_EXADDR'(nxt - CW'(NUM_BOOT_PAD));
  assign in_pad = cnt_q < CW'(NUM_BOOT_PAD);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (I_Boot) begin
        state_d = BOOT;
        cnt_d = '0;
      end
      BOOT: begin
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(TOT - 1)) ? SERVE : BOOT;
      end
      default: state_d = stall ? HOLD : SERVE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  ext_mem_ld_queue u_q (
    .clock    (clock),
    .reset    (reset),
    .active   (active),
    .port_free(active & ~st_ok),
    .ld_req   (I_Ld_Req),
    .ld_addr  (I_Ld_Addr),
    .bt_n     (I_Ld_BTk.n),
    .rdata    (I_Mem_RData),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .stall    (stall),
    .pend_v   (pend_v),
    .tok      (q_tok)
  );
  assign O_Mem_En = st_ok | rd_en | boot_rd;
  assign O_Mem_We = st_ok;
  assign O_Mem_Addr = st_ok ? I_St_Addr : boot_rd ? boot_addr : rd_en ? rd_addr : '0;
  assign O_Mem_WData = st_ok ? I_St_FTk.d : '0;
`ifdef EXTEND_MEM_EN
  assign boot_i = in_pad ? '0 : WIDTH_EXADDR'(cnt_q - CW'(NUM_BOOT_PAD));
`else
  assign boot_i = '0;
`endif
  assign O_Ld_FTk = (state_q == BOOT)
    ? FTk_t'{v: 1'b1, a: (cnt_q == '0), r: 1'b0, c: 1'b0, i: boot_i, d: in_pad ? '0 : I_Mem_RData}
    : q_tok;
  assign O_St_BTk = '{n: st_n, t: 1'b0, v: 1'b0, c: 1'b0};
  assign O_Busy = (state_q == BOOT) | (state_q == HOLD) | pend_v;
  assign unused_ok = ^{I_Ld_BTk.t, I_Ld_BTk.v, I_Ld_BTk.c, I_St_FTk.a, I_St_FTk.r, I_St_FTk.c, I_St_FTk.i};
endmodule

// File: tb/tb_ext_mem_bridge.sv
// tb_ext_mem_bridge: scoreboard bench for ext_mem_bridge with a BRAM model and a reference memory.
// Build with EXTEND_MEM_EN defined to also check address tags.
module tb_ext_mem_bridge;
  import pkg_en::*;
  localparam int NB = 3, DB = 5, TOT = NB + DB;
  typedef struct packed {
    logic a;
    logic [WIDTH_EXADDR-1:0] i;
    logic [WIDTH_DATA-1:0] d;
  } exp_t;
  logic clock = 1'b0, reset = 1'b1, I_Boot = 1'b0, I_Ld_Req = 1'b0, I_St_Req = 1'b0;
  logic [WIDTH_EXADDR-1:0] I_Ld_Addr = '0, I_St_Addr = '0, O_Mem_Addr, mon_i, sa;
  logic [WIDTH_DATA-1:0] I_Mem_RData = '0, O_Mem_WData, sd;
  logic O_Mem_En, O_Mem_We, O_Busy;
  FTk_t O_Ld_FTk, I_St_FTk = '0;
  BTk_t I_Ld_BTk = '0, O_St_BTk;
  logic [WIDTH_DATA-1:0] bram [256];
  logic [WIDTH_DATA-1:0] ref_mem [256];
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  ext_mem_bridge #(.DEPTH_BOOT(DB), .NUM_BOOT_PAD(NB)) dut (
    .clock(clock), .reset(reset), .I_Boot(I_Boot),
    .I_Ld_Req(I_Ld_Req), .I_Ld_Addr(I_Ld_Addr), .O_Ld_FTk(O_Ld_FTk), .I_Ld_BTk(I_Ld_BTk),
    .I_St_Req(I_St_Req), .I_St_Addr(I_St_Addr), .I_St_FTk(I_St_FTk), .O_St_BTk(O_St_BTk),
    .O_Mem_En(O_Mem_En), .O_Mem_We(O_Mem_We), .O_Mem_Addr(O_Mem_Addr),
    .O_Mem_WData(O_Mem_WData), .I_Mem_RData(I_Mem_RData), .O_Busy(O_Busy)
  );

  always @(posedge clock) begin
    if (O_Mem_En) begin
      if (O_Mem_We) bram[O_Mem_Addr] <= O_Mem_WData;
      I_Mem_RData <= bram[O_Mem_Addr];
    end
  end

  // every presented token is compared with the oldest expectation; popped only when accepted
  always @(negedge clock) begin
    if (!reset && O_Ld_FTk.v) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_token: got a=%b d=%h i=%h, required no token", O_Ld_FTk.a, O_Ld_FTk.d, O_Ld_FTk.i);
      end else begin
        mon_e = sb[0];
`ifdef EXTEND_MEM_EN
        mon_i = mon_e.i;
`else
        mon_i = '0;
`endif
        if ({O_Ld_FTk.a, O_Ld_FTk.r, O_Ld_FTk.c, O_Ld_FTk.i, O_Ld_FTk.d} !== {mon_e.a, 2'b00, mon_i, mon_e.d}) begin
          errors++;
          $display("FAIL token: got a=%b r=%b c=%b i=%h d=%h, required a=%b r=0 c=0 i=%h d=%h",
                   O_Ld_FTk.a, O_Ld_FTk.r, O_Ld_FTk.c, O_Ld_FTk.i, O_Ld_FTk.d, mon_e.a, mon_i, mon_e.d);
        end
        if (!I_Ld_BTk.n) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  function automatic void push(input logic pa, input logic [WIDTH_EXADDR-1:0] pi, input logic [WIDTH_DATA-1:0] pd);
    sb.push_back(exp_t'{a: pa, i: pi, d: pd});
  endfunction

  function automatic void push_boot(input int n);
    for (int k = 0; k < n; k++) begin
      if (k < NB) push(k == 0, '0, '0);
      else push(k == 0, WIDTH_EXADDR'(k - NB), ref_mem[k - NB]);
    end
  endfunction

  function automatic FTk_t st_tok(input logic v, input logic [WIDTH_DATA-1:0] d);
    st_tok = '0;
    st_tok.v = v;
    st_tok.d = d;
  endfunction

  task automatic load(input logic [WIDTH_EXADDR-1:0] a);
    I_Ld_Req = 1'b1;
    I_Ld_Addr = a;
    push(1'b0, a, ref_mem[a]);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) tick();
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ftk"}, 32'(O_Ld_FTk), 0);
    chk({tag, "_mem_en"}, 32'(O_Mem_En), 0);
    chk({tag, "_mem_we"}, 32'(O_Mem_We), 0);
    chk({tag, "_busy"}, 32'(O_Busy), 0);
    chk({tag, "_mem_addr"}, 32'(O_Mem_Addr), 0);
    chk({tag, "_st_btk"}, 32'(O_St_BTk), 32'h8);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      sd = WIDTH_DATA'($urandom);
      if (k < DB) sd = WIDTH_DATA'(k + 1);
      if (k == 16) sd = 16'hCAFE;
      bram[k] <= sd;
      ref_mem[k] = sd;
    end
    repeat (3) tick();
    @(negedge clock);
    chk_reset("rst");
    tick();
    reset = 1'b0;
    // boot sequence, with a store attempt and a stray I_Boot while booting
    push_boot(TOT);
    I_Boot = 1'b1;
    tick();
    I_Boot = 1'b0;
    for (int k = 0; k < TOT; k++) begin
      if (k == 2) begin
        I_St_Req = 1'b1;
        I_St_Addr = 8'h30;
        I_St_FTk = st_tok(1'b1, 16'hDEAD);
      end
      if (k == 5) I_Boot = 1'b1;
      @(negedge clock);
      if (k == 2) begin
        chk("boot_st_nack", 32'(O_St_BTk.n), 1);
        chk("boot_no_we", 32'(O_Mem_We), 0);
        chk("boot_busy", 32'(O_Busy), 1);
      end
      tick();
      I_St_Req = 1'b0;
      I_Boot = 1'b0;
    end
    @(negedge clock);
    chk("boot_end_v", 32'(O_Ld_FTk.v), 0);
    chk("serve_st_ack", 32'(O_St_BTk.n), 0);
    chk("boot_tokens_done", sb.size(), 0);
    // load latency of two cycles
    tick();
    load(8'h10);
    tick();
    I_Ld_Req = 1'b0;
    @(negedge clock);
    chk("lat2_early", 32'(O_Ld_FTk.v), 0);
    tick();
    @(negedge clock);
    chk("lat2_v", 32'(O_Ld_FTk.v), 1);
    chk("lat2_d", 32'(O_Ld_FTk.d), 32'hCAFE);
`ifdef EXTEND_MEM_EN
    chk("lat2_i", 32'(O_Ld_FTk.i), 32'h10);
`endif
    // store and load collide on 0x20
    tick();
    I_St_Req = 1'b1;
    I_St_Addr = 8'h20;
    I_St_FTk = st_tok(1'b1, 16'hBEEF);
    ref_mem[8'h20] = 16'hBEEF;
    load(8'h20);
    @(negedge clock);
    chk("col_we", 32'(O_Mem_We), 1);
    chk("col_addr", 32'(O_Mem_Addr), 32'h20);
    chk("col_wdata", 32'(O_Mem_WData), 32'hBEEF);
    tick();
    I_St_Req = 1'b0;
    I_Ld_Req = 1'b0;
    @(negedge clock);
    chk("col_pend_busy", 32'(O_Busy), 1);
    chk("col_issue_en", 32'(O_Mem_En), 1);
    tick();
    @(negedge clock);
    chk("col_v_early", 32'(O_Ld_FTk.v), 0);
    tick();
    @(negedge clock);
    chk("col_v", 32'(O_Ld_FTk.v), 1);
    chk("col_d", 32'(O_Ld_FTk.d), 32'hBEEF);
    // back-pressure on the first of three loads
    tick();
    load(8'd1);
    tick();
    load(8'd2);
    tick();
    load(8'd3);
    I_Ld_BTk.n = 1'b1;
    @(negedge clock);
    chk("bp_first_d", 32'(O_Ld_FTk.d), 32'(ref_mem[1]));
    for (int k = 0; k < 3; k++) begin
      tick();
      I_Ld_Req = 1'b0;
      @(negedge clock);
      chk("bp_hold_v", 32'(O_Ld_FTk.v), 1);
      chk("bp_hold_d", 32'(O_Ld_FTk.d), 32'(ref_mem[1]));
      chk("bp_busy", 32'(O_Busy), 1);
    end
    tick();
    I_Ld_BTk.n = 1'b0;
    drain(20);
    // random traffic: loads in the lower half, stores in the upper half
    for (int c = 0; c < 400; c++) begin
      tick();
      I_Ld_Req = 1'b0;
      I_St_Req = 1'b0;
      I_Boot = ($urandom_range(0, 19) == 0);
      I_Ld_BTk.n = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        sa = WIDTH_EXADDR'(128 + $urandom_range(0, 127));
        sd = WIDTH_DATA'($urandom);
        I_St_Req = 1'b1;
        I_St_Addr = sa;
        I_St_FTk = st_tok($urandom_range(0, 3) != 0, sd);
        if (I_St_FTk.v) ref_mem[sa] = sd;
      end
      if (!O_Busy && $urandom_range(0, 1) == 1) load(WIDTH_EXADDR'($urandom_range(0, 127)));
    end
    tick();
    I_Ld_Req = 1'b0;
    I_St_Req = 1'b0;
    I_Boot = 1'b0;
    I_Ld_BTk.n = 1'b0;
    drain(50);
    // read back the whole store region plus the address targeted during boot
    for (int k = 0; k <= 128; k++) begin
      tick();
      I_Ld_Req = 1'b0;
      if (!O_Busy) load(k == 128 ? 8'h30 : WIDTH_EXADDR'(128 + k));
    end
    tick();
    I_Ld_Req = 1'b0;
    drain(20);
    // reset in the middle of boot, then reboot
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    push_boot(4);
    I_Boot = 1'b1;
    tick();
    I_Boot = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    @(negedge clock);
    chk_reset("abort");
    chk("abort_tokens_seen", sb.size(), 0);
    tick();
    reset = 1'b0;
    repeat (6) begin
      tick();
      @(negedge clock);
      chk("abort_quiet_v", 32'(O_Ld_FTk.v), 0);
    end
    push_boot(TOT);
    tick();
    I_Boot = 1'b1;
    tick();
    I_Boot = 1'b0;
    @(negedge clock);
    chk("reboot_a", 32'(O_Ld_FTk.a), 1);
    drain(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
